// File: rtl/arf086b256e1r1w0cbbeheaa4acw_swt_obs_pkg.sv
// Shared types and the signature step for the SWT observation sequencer.
// Signatures are at most SIG_MAX_W bits wide; the step rotates within the low 'width' bits.
package arf086b256e1r1w0cbbeheaa4acw_swt_obs_pkg;

   localparam int SIG_MAX_W = 32;
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_UNLOAD  = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   function automatic logic [SIG_MAX_W-1:0] sig_rotl_xor(
      input logic [SIG_MAX_W-1:0] sig,
      input logic [SIG_MAX_W-1:0] obs,
      input int                   width
   );
      logic [SIG_MAX_W-1:0] rot;
      rot = sig << 1;
      for (int i = 0; i < SIG_MAX_W; i++) begin
         if (i == width - 1) rot[0] = sig[i];
         if (i >= width)     rot[i] = 1'b0;
      end
      return rot ^ obs;
   endfunction

endpackage

// File: rtl/arf086b256e1r1w0cbbeheaa4acw_swt_obs_ctrl_if.sv
// Unload handshake: one signature per transfer, tagged with its port index.
// Producer holds data/port stable while valid is high and ready is low.
interface arf086b256e1r1w0cbbeheaa4acw_swt_obs_ctrl_if #(
   parameter int OBS_W  = 4,
   parameter int PORT_W = 1
);
   logic [OBS_W-1:0]  unload_data;
   logic [PORT_W-1:0] unload_port;
   logic              unload_valid;
   logic              unload_ready;

   modport master (
      output unload_data,
      output unload_port,
      output unload_valid,
      input  unload_ready
   );

   modport slave (
      input  unload_data,
      input  unload_port,
      input  unload_valid,
      output unload_ready
   );
endinterface

// File: rtl/arf086b256e1r1w0cbbeheaa4acw_swt_obs_sig_acc.sv
// Per-port signature register: clear wins over enable; updates one cycle after en_i.
// No backpressure: holds its value whenever neither clear nor enable is set.
module arf086b256e1r1w0cbbeheaa4acw_swt_obs_sig_acc
   import arf086b256e1r1w0cbbeheaa4acw_swt_obs_pkg::*;
#(
   parameter int OBS_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [OBS_W-1:0] obs_i,
   output logic [OBS_W-1:0] sig_o
);

   logic [OBS_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = OBS_W'(sig_rotl_xor(SIG_MAX_W'(sig_q), SIG_MAX_W'(obs_i), OBS_W));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) sig_q <= '0;
      else       sig_q <= sig_d;
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/arf086b256e1r1w0cbbeheaa4acw_swt_obs_ctrl.sv
// SWT observation sequencer: CAP_CYCLES capture cycles, then unloads enabled ports in index order.
// Unload is valid/ready; a stalled port holds data/port until accepted, then DONE pulses for one cycle.
module arf086b256e1r1w0cbbeheaa4acw_swt_obs_ctrl
   import arf086b256e1r1w0cbbeheaa4acw_swt_obs_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int OBS_W      = 4,
   parameter int CAP_CYCLES = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [NUM_PORTS-1:0]         port_en,
   input  logic [NUM_PORTS*OBS_W-1:0]   obs_in,
   arf086b256e1r1w0cbbeheaa4acw_swt_obs_ctrl_if.master unload,
   output logic                         busy,
   output logic                         done
);

   localparam int              PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAP_CYCLES - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_PORTS-1:0] en_q, en_d;
   logic [PORT_W-1:0]   ptr_q, ptr_d;

   logic [OBS_W-1:0]    sig [NUM_PORTS];
   logic                sig_clr, sig_en;
   logic                first_vld, next_vld;
   logic [PORT_W-1:0]   first_idx, next_idx;
   logic                vld;
   logic [OBS_W-1:0]    data_mux;

   assign sig_clr = (state_q == ST_IDLE) && start;
   assign sig_en  = (state_q == ST_CAPTURE);

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_sig
      arf086b256e1r1w0cbbeheaa4acw_swt_obs_sig_acc #(
         .OBS_W (OBS_W)
      ) u_sig_acc (
         .clk_i (clock),
         .rst_i (reset),
         .clr_i (sig_clr),
         .en_i  (sig_en),
         .obs_i (obs_in[g*OBS_W +: OBS_W]),
         .sig_o (sig[g])
      );
   end

   // Descending scan so the lowest qualifying index wins.
   always_comb begin
      first_vld = 1'b0;
      first_idx = '0;
      next_vld  = 1'b0;
      next_idx  = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
         if (en_q[p]) begin
            first_vld = 1'b1;
            first_idx = PORT_W'(p);
         end
         if (en_q[p] && (PORT_W'(p) > ptr_q)) begin
            next_vld = 1'b1;
            next_idx = PORT_W'(p);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CAPTURE;
               cnt_d   = '0;
               en_d    = port_en;
               ptr_d   = '0;
            end
         end
         ST_CAPTURE: begin
            if (cnt_q == CNT_LAST) begin
               if (first_vld) begin
                  state_d = ST_UNLOAD;
                  ptr_d   = first_idx;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_UNLOAD: begin
            if (unload.unload_ready) begin
               if (next_vld) ptr_d   = next_idx;
               else          state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         en_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         ptr_q   <= ptr_d;
      end
   end

   assign vld = (state_q == ST_UNLOAD);

   always_comb begin
      data_mux = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (vld && (PORT_W'(p) == ptr_q)) data_mux = sig[p];
      end
   end

   assign unload.unload_valid = vld;
   assign unload.unload_data  = data_mux;
   assign unload.unload_port  = vld ? ptr_q : '0;
   assign busy                = (state_q != ST_IDLE);
   assign done                = (state_q == ST_DONE);

endmodule
